// File: rtl/strat_pkg.sv
// rtl/strat_pkg.sv - shared feed message field slices, types and helpers
package strat_pkg;

  localparam int MSG_TYPE_HI = 63;
  localparam int MSG_TYPE_LO = 48;
  localparam int SYM_HI      = 47;
  localparam int SYM_LO      = 32;
  localparam int PRICE_HI    = 63;
  localparam int PRICE_LO    = 32;
  localparam int VOL_HI      = 31;
  localparam int VOL_LO      = 0;

  localparam int SYM_W = SYM_HI - SYM_LO + 1;

  localparam logic [15:0] MSG_TYPE_TRADE = 16'h0001;

  typedef enum logic [1:0] {
    WAIT_SOP,
    BEAT0,
    BEAT1
  } parse_state_t;

  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic [31:0]      price;
    logic [31:0]      volume;
  } feed_msg_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/feed_msg_parser_if.sv
// rtl/feed_msg_parser_if.sv - market-data feed beat stream (valid/ready with sop/eop framing)
interface feed_msg_parser_if #(
  parameter int DATA_W = 64
) ();

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sop;
  logic              eop;
  logic              ready;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);

endinterface

// File: rtl/msg_delay_pipe.sv
// rtl/msg_delay_pipe.sv - fixed-depth valid-tagged shift pipeline aligning messages with RAM read data
module msg_delay_pipe
  import strat_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  input  feed_msg_t in_msg,
  output logic      out_valid,
  output feed_msg_t out_msg
);

  logic [DEPTH-1:0] vld;
  feed_msg_t        stage [DEPTH];

  // Only the valid tags need flushing; payload is ignored unless tagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    stage[0] <= in_msg;
    for (int i = 1; i < DEPTH; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_msg   = stage[DEPTH-1];

endmodule

// File: rtl/feed_msg_parser.sv
// rtl/feed_msg_parser.sv - parses two-beat feed messages, issues symbol reads, aligns fields with RAM data
module feed_msg_parser #(
  parameter int          DATA_W         = 64,
  parameter int          ADDR_W         = 10,
  parameter int          RCB_RD_LAT     = 2,
  parameter logic [15:0] MSG_TYPE_TRADE = strat_pkg::MSG_TYPE_TRADE
) (
  input  logic               clk,
  input  logic               reset,
  feed_msg_parser_if.slave   feed,
  output logic [ADDR_W-1:0]  t2t_rd_addr,
  output logic               sef_read,
  output logic               slf_inmsg,
  output logic [ADDR_W-1:0]  msg_sym,
  output logic [31:0]        msg_price,
  output logic [31:0]        msg_volume,
  output logic [15:0]        drop_cnt
);

  import strat_pkg::*;

  logic [DATA_W-1:0] beat;
  logic              ready_q;
  logic              accept;
  parse_state_t      state_q;
  parse_state_t      state_d;
  logic              capture;
  logic              complete;
  logic              frame_err;
  logic [15:0]       type_q;
  logic [ADDR_W-1:0] sym_q;
  logic              issue;
  feed_msg_t         pipe_in;
  feed_msg_t         pipe_out;
  logic              pipe_valid;

  assign beat       = feed.data;
  assign feed.ready = ready_q;
  assign accept     = feed.valid & ready_q;

  always_ff @(posedge clk) begin
    ready_q <= ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_SOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    complete  = 1'b0;
    frame_err = 1'b0;
    if (accept) begin
      case (state_q)
        WAIT_SOP: begin
          if (feed.sop && feed.eop) begin
            frame_err = 1'b1;
          end else if (feed.sop) begin
            capture = 1'b1;
            state_d = BEAT1;
          end
        end
        BEAT0: begin
          if (feed.eop) begin
            frame_err = 1'b1;
            state_d   = WAIT_SOP;
          end else begin
            capture = 1'b1;
            state_d = BEAT1;
          end
        end
        BEAT1: begin
          // A sop here abandons the half-parsed message; the beat restarts as beat0.
          if (feed.sop) begin
            frame_err = 1'b1;
            capture   = 1'b1;
            state_d   = feed.eop ? WAIT_SOP : BEAT1;
          end else begin
            complete = 1'b1;
            state_d  = feed.eop ? WAIT_SOP : BEAT0;
          end
        end
        default: state_d = WAIT_SOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      type_q <= '0;
      sym_q  <= '0;
    end else if (capture) begin
      type_q <= beat[MSG_TYPE_HI:MSG_TYPE_LO];
      sym_q  <= beat[SYM_LO +: ADDR_W];
    end
  end

  assign issue = complete && (type_q == MSG_TYPE_TRADE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sef_read    <= 1'b0;
      t2t_rd_addr <= '0;
    end else begin
      sef_read <= issue;
      if (issue) begin
        t2t_rd_addr <= sym_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (frame_err) begin
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  always_comb begin
    pipe_in        = '0;
    pipe_in.sym    = SYM_W'(sym_q);
    pipe_in.price  = beat[PRICE_HI:PRICE_LO];
    pipe_in.volume = beat[VOL_HI:VOL_LO];
  end

  // The pipeline is loaded on the beat1 edge, so its depth plus the output
  // register below lands the strobe RCB_RD_LAT cycles after sef_read.
  msg_delay_pipe #(
    .DEPTH (RCB_RD_LAT)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue),
    .in_msg    (pipe_in),
    .out_valid (pipe_valid),
    .out_msg   (pipe_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slf_inmsg  <= 1'b0;
      msg_sym    <= '0;
      msg_price  <= '0;
      msg_volume <= '0;
    end else begin
      slf_inmsg <= pipe_valid;
      if (pipe_valid) begin
        msg_sym    <= pipe_out.sym[ADDR_W-1:0];
        msg_price  <= pipe_out.price;
        msg_volume <= pipe_out.volume;
      end
    end
  end

  generate
    if (ADDR_W < SYM_W) begin : g_sym_trim
      logic unused_sym_bits;
      assign unused_sym_bits = ^pipe_out.sym[SYM_W-1:ADDR_W];
    end
  endgenerate

endmodule

// File: tb/tb_feed_msg_parser.sv
// tb/tb_feed_msg_parser.sv - directed self-checking bench for feed_msg_parser
module tb_feed_msg_parser;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;

  typedef struct {
    int              cyc;
    logic [ADDR_W-1:0] sym;
    logic [31:0]     price;
    logic [31:0]     vol;
  } rec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] t2t_rd_addr;
  logic              sef_read;
  logic              slf_inmsg;
  logic [ADDR_W-1:0] msg_sym;
  logic [31:0]       msg_price;
  logic [31:0]       msg_volume;
  logic [15:0]       drop_cnt;

  int   cyc = 0;
  int   last_b = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  rec_t obs_rd[$];
  rec_t obs_im[$];
  rec_t exp_rd[$];
  rec_t exp_im[$];

  feed_msg_parser_if #(.DATA_W(64)) feed ();

  feed_msg_parser #(
    .DATA_W         (64),
    .ADDR_W         (ADDR_W),
    .RCB_RD_LAT     (LAT),
    .MSG_TYPE_TRADE (16'h0001)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .feed        (feed),
    .t2t_rd_addr (t2t_rd_addr),
    .sef_read    (sef_read),
    .slf_inmsg   (slf_inmsg),
    .msg_sym     (msg_sym),
    .msg_price   (msg_price),
    .msg_volume  (msg_volume),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (sef_read)  obs_rd.push_back('{cyc, t2t_rd_addr, 32'd0, 32'd0});
    if (slf_inmsg) obs_im.push_back('{cyc, msg_sym, msg_price, msg_volume});
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic s, input logic e);
    @(negedge clk);
    feed.data  = d;
    feed.valid = 1'b1;
    feed.sop   = s;
    feed.eop   = e;
    @(posedge clk);
    #1;
    last_b = cyc;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      feed.valid = 1'b0;
      feed.sop   = 1'b0;
      feed.eop   = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_trade(input int b, input logic [ADDR_W-1:0] sym,
                              input logic [31:0] price, input logic [31:0] vol);
    exp_rd.push_back('{b, sym, 32'd0, 32'd0});
    exp_im.push_back('{b + LAT, sym, price, vol});
  endtask

  task automatic msg(input logic [15:0] typ, input logic [15:0] sym, input logic [31:0] price,
                     input logic [31:0] vol, input logic s, input logic e, input int mid_gap);
    beat({typ, sym, 32'hDEAD_BEEF}, s, 1'b0);
    if (mid_gap > 0) gap(mid_gap);
    beat({price, vol}, 1'b0, e);
    if (typ == 16'h0001) expect_trade(last_b, sym[ADDR_W-1:0], price, vol);
  endtask

  task automatic verify(input string tag);
    int n;
    check({tag, " rd_count"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
    n = (obs_rd.size() < exp_rd.size()) ? obs_rd.size() : exp_rd.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " rd_cyc"}, 64'(obs_rd[i].cyc), 64'(exp_rd[i].cyc));
      check({tag, " rd_addr"}, 64'(obs_rd[i].sym), 64'(exp_rd[i].sym));
    end
    check({tag, " im_count"}, 64'(obs_im.size()), 64'(exp_im.size()));
    n = (obs_im.size() < exp_im.size()) ? obs_im.size() : exp_im.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " im_cyc"}, 64'(obs_im[i].cyc), 64'(exp_im[i].cyc));
      check({tag, " im_sym"}, 64'(obs_im[i].sym), 64'(exp_im[i].sym));
      check({tag, " im_price"}, 64'(obs_im[i].price), 64'(exp_im[i].price));
      check({tag, " im_vol"}, 64'(obs_im[i].vol), 64'(exp_im[i].vol));
    end
    obs_rd.delete();
    obs_im.delete();
    exp_rd.delete();
    exp_im.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " feed_ready"}, 64'(feed.ready), 64'd0);
    check({tag, " sef_read"}, 64'(sef_read), 64'd0);
    check({tag, " slf_inmsg"}, 64'(slf_inmsg), 64'd0);
    check({tag, " rd_addr"}, 64'(t2t_rd_addr), 64'd0);
    check({tag, " msg_sym"}, 64'(msg_sym), 64'd0);
    check({tag, " msg_price"}, 64'(msg_price), 64'd0);
    check({tag, " msg_volume"}, 64'(msg_volume), 64'd0);
    check({tag, " drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  logic [15:0] syms   [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
  logic [31:0] prices [4] = '{32'd1000, 32'd1001, 32'd1002, 32'd1003};
  logic [31:0] vols   [4] = '{32'd10, 32'd20, 32'd30, 32'd40};

  initial begin
    feed.data  = '0;
    feed.valid = 1'b0;
    feed.sop   = 1'b0;
    feed.eop   = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(feed.ready), 64'd1);
    gap(1);

    // single trade packet
    msg(16'h0001, 16'h0005, 32'd100, 32'd7, 1'b1, 1'b1, 0);
    gap(LAT + 4);
    verify("single");

    // four back-to-back trades in one packet
    for (int i = 0; i < 4; i++)
      msg(16'h0001, syms[i], prices[i], vols[i], i == 0, i == 3, 0);
    gap(LAT + 4);
    verify("b2b4");

    // non-trade between two trades
    msg(16'h0001, 16'h0021, 32'd500, 32'd5, 1'b1, 1'b0, 0);
    msg(16'h0002, 16'h0022, 32'd600, 32'd6, 1'b0, 1'b0, 0);
    msg(16'h0001, 16'h0023, 32'd700, 32'd7, 1'b0, 1'b1, 0);
    gap(LAT + 4);
    verify("nontrade");
    check("nontrade drop_cnt", 64'(drop_cnt), 64'd0);

    // sop in BEAT1: drop, restart with new beat0
    beat({16'h0001, 16'h0009, 32'h0}, 1'b1, 1'b0);
    beat({16'h0001, 16'h000A, 32'h0}, 1'b1, 1'b0);
    beat({32'd900, 32'd9}, 1'b0, 1'b1);
    expect_trade(last_b, 10'd10, 32'd900, 32'd9);
    gap(1);
    check("frame sop_in_beat1 drop_cnt", 64'(drop_cnt), 64'd1);
    // eop on a sop beat0, then a stray non-sop beat that is silently discarded
    beat({16'h0001, 16'h000B, 32'h0}, 1'b1, 1'b1);
    beat({32'd1, 32'd1}, 1'b0, 1'b0);
    gap(1);
    check("frame eop_on_beat0 drop_cnt", 64'(drop_cnt), 64'd2);
    // eop on a beat0 reached in BEAT0
    msg(16'h0001, 16'h000D, 32'd1300, 32'd13, 1'b1, 1'b0, 0);
    beat({16'h0001, 16'h000E, 32'h0}, 1'b0, 1'b1);
    gap(1);
    check("frame eop_in_beat0 drop_cnt", 64'(drop_cnt), 64'd3);
    msg(16'h0001, 16'h000C, 32'd1200, 32'd12, 1'b1, 1'b1, 0);
    gap(LAT + 4);
    verify("frame_resume");
    check("frame_resume drop_cnt", 64'(drop_cnt), 64'd3);

    // random gaps inside and between messages
    for (int i = 0; i < 4; i++) begin
      msg(16'h0001, syms[i], prices[i], vols[i], i == 0, i == 3, $urandom_range(0, 3));
      gap($urandom_range(0, 2));
    end
    gap(LAT + 4);
    verify("gaps");

    // reset one cycle after beat1: read already out, message flushed
    msg(16'h0001, 16'h0014, 32'd2000, 32'd20, 1'b1, 1'b1, 0);
    exp_im.delete();
    @(negedge clk);
    feed.valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    gap(LAT + 4);
    verify("mid_reset");
    msg(16'h0001, 16'h0015, 32'd2100, 32'd21, 1'b1, 1'b1, 0);
    gap(LAT + 4);
    verify("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/feed_msg_parser.md
# feed_msg_parser

Upstream feed stage of the tick-to-trade strategy block. It accepts the Avalon-ST market-data feed and parses each packet into fixed two-beat messages. For each trade message it issues one symbol-indexed read to the strategy RAM control blocks. It then presents the message price and volume to the comparator, aligned with the returned RAM data.

## Interface
Parameters:
- DATA_W, 64: feed beat width; fixed at 64, no other value is supported.
- ADDR_W, 10: RAM control block read-address width (symbol index).
- RCB_RD_LAT, 2: cycles from `sef_read` to valid RAM control block data; legal range 1–8.
- MSG_TYPE_TRADE, 16'h0001: message type that triggers a read.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- feed_data  in  DATA_W  feed beat.
- feed_valid  in  1  beat valid.
- feed_sop  in  1  first beat of a packet.
- feed_eop  in  1  last beat of a packet.
- feed_ready  out  1  beat accepted when high together with `feed_valid`.
- t2t_rd_addr  out  ADDR_W  symbol index to all RAM control blocks.
- sef_read  out  1  one-cycle read strobe.
- slf_inmsg  out  1  one-cycle strobe; message fields are valid and aligned with RAM control block data.
- msg_sym  out  ADDR_W  symbol index of the presented message.
- msg_price  out  32  message price.
- msg_volume  out  32  message volume.
- drop_cnt  out  16  count of discarded messages; saturates at 16'hFFFF.

## Operation
- Message format, two beats:
  - beat0: [63:48] msg_type, [47:32] sym_idx (low ADDR_W bits used; upper bits ignored), [31:0] reserved.
  - beat1: [63:32] price, [31:0] volume.
- A packet carries 1..N messages. `feed_sop` marks beat0 of the first message; `feed_eop` marks beat1 of the last.
- There is no downstream backpressure. `feed_ready` = !reset and is registered, so it is 0 during reset and 1 from the first cycle after reset.
- FSM states:
  - WAIT_SOP, the reset state:
    - A beat with sop goes to BEAT1 (that beat is beat0); msg_type and sym_idx are captured.
    - A beat without sop is discarded with no count.
  - BEAT0:
    - A beat without sop goes to BEAT1; fields are captured.
    - A beat with sop starts a new packet; it is captured as beat0 and the FSM goes to BEAT1. There is no drop, because the previous message completed.
  - BEAT1:
    - A beat without sop or eop completes the message and goes to BEAT0.
    - A beat with eop and without sop completes the message and goes to WAIT_SOP.
    - A beat with sop is a framing error. drop_cnt increments by 1, and the beat is treated as a new beat0; the FSM stays in BEAT1 with fields recaptured.
  - eop on any beat0 (in WAIT_SOP or BEAT0) is a framing error. drop_cnt increments by 1 and the FSM goes to WAIT_SOP.
- On message completion:
  - If msg_type == MSG_TYPE_TRADE, a read is issued.
  - Otherwise the message is ignored silently, with no read and no count.
- Gaps (valid low) are legal between any beats; FSM state and captured fields hold across gaps.

## Timing
- Beat1 of a trade message accepted at cycle B gives:
  - `sef_read`=1 and `t2t_rd_addr`=sym at B+1.
  - `slf_inmsg`=1 with msg_sym, msg_price and msg_volume at B+1+RCB_RD_LAT.
- Price, volume and sym travel through an RCB_RD_LAT-deep valid-tagged shift pipeline. Every message in flight is delivered, in order, with no loss.
- Maximum rate is one read per 2 cycles. The pipeline never stalls.
- Reset values:
  - feed_ready, sef_read and slf_inmsg are 0.
  - t2t_rd_addr, msg_sym, msg_price, msg_volume and drop_cnt are 0.
  - The FSM returns to WAIT_SOP.
- Reset asserted mid-message or mid-pipeline flushes everything. No strobe fires after the reset cycle for messages accepted before it.
- t2t_rd_addr and the msg_* outputs hold their last value when their strobe is low.

## Structure
- Shared strat_pkg holds:
  - Field slice constants (MSG_TYPE_HI/LO, SYM_HI/LO, PRICE_HI/LO, VOL_HI/LO).
  - MSG_TYPE_TRADE.
  - The FSM state enum parse_state_t.
  - A struct feed_msg_t {sym, price, volume}.
- One sub-module, msg_delay_pipe, implements the parameterised RCB_RD_LAT-deep valid plus feed_msg_t shift register.

## Test plan
- Single trade packet: sop beat0 {0001,0x0005}, eop beat1 {price=100, volume=7} accepted at B.
  - `sef_read` with addr=5 at B+1.
  - `slf_inmsg` with sym=5, price=100, volume=7 at B+3 (RCB_RD_LAT=2).
- Back-to-back packet of 4 trade messages, no gaps: four `sef_read` pulses, 2 cycles apart, with addresses in order; four `slf_inmsg` pulses with matching data.
- Non-trade type 16'h0002 between two trades: only 2 reads and 2 `slf_inmsg` pulses; drop_cnt stays 0.
- Framing errors: a new sop arriving in BEAT1 and eop on a beat0 each increment drop_cnt (to 1, then 2). Parsing resumes correctly on the next sop packet.
- Random valid gaps inside messages: outputs are identical to the gap-free run except for timing; each `slf_inmsg` occurs exactly RCB_RD_LAT+1 cycles after its beat1.
- Reset asserted 1 cycle after a beat1 is accepted: no `slf_inmsg` afterwards; all outputs 0; the next clean packet is parsed normally.
